// File: rtl/change_dispenser_if.sv
// Handshake bundle between the vending controller, the coin ejector and
// the change dispenser. Signal names keep their i_/o_ direction prefixes
// as seen from the dispenser.
interface change_dispenser_if #(
  parameter int AMT_W = 8
);
  logic             i_req_valid;
  logic [AMT_W-1:0] i_req_amount;
  logic             o_req_ready;
  logic             o_coin_valid;
  logic [1:0]       o_coin_type;
  logic             i_coin_ack;
  logic             o_done;
  logic             o_short;
  logic [AMT_W-1:0] o_short_amount;
  logic             i_refill;
  logic [1:0]       i_refill_type;
  logic [3:0]       o_empty;

  // Controller/ejector/refill side.
  modport master (
    output i_req_valid, i_req_amount, i_coin_ack, i_refill, i_refill_type,
    input  o_req_ready, o_coin_valid, o_coin_type, o_done, o_short,
           o_short_amount, o_empty
  );

  // Dispenser side.
  modport slave (
    input  i_req_valid, i_req_amount, i_coin_ack, i_refill, i_refill_type,
    output o_req_ready, o_coin_valid, o_coin_type, o_done, o_short,
           o_short_amount, o_empty
  );
endinterface

// File: rtl/change_dispenser.sv
// Change dispenser: pays out a change amount one coin at a time, greedily
// choosing the largest coin that fits and is in stock. Reports the unpaid
// remainder when inventory cannot cover the amount.
module change_dispenser #(
  parameter int AMT_W    = 8,
  parameter int CNT_W    = 6,
  parameter int INIT_CNT = 10
) (
  input  logic              i_clk,
  input  logic              i_reset,
  change_dispenser_if.slave bus
);

  typedef enum logic [1:0] {IDLE, PICK, ISSUE, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(INIT_CNT);

  state_t           state, state_next;
  logic [AMT_W-1:0] remaining;
  logic [AMT_W-1:0] remaining_after;
  logic [1:0]       coin_type;
  logic             short_q;
  logic [AMT_W-1:0] short_amt;
  logic [CNT_W-1:0] count [4];
  logic             pick_found;
  logic [1:0]       pick_type;
  logic             ack_take;

  // Coin face values in cents: 1c, 5c, 10c, 25c.
  function automatic logic [AMT_W-1:0] coin_value(input logic [1:0] d);
    case (d)
      2'd0:    coin_value = AMT_W'(1);
      2'd1:    coin_value = AMT_W'(5);
      2'd2:    coin_value = AMT_W'(10);
      default: coin_value = AMT_W'(25);
    endcase
  endfunction

  assign ack_take        = (state == ISSUE) && bus.i_coin_ack;
  assign remaining_after = remaining - coin_value(coin_type);

  // Greedy choice: scan upward so the highest eligible denomination wins.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    pick_found = 1'b0;
    pick_type  = 2'd0;
    for (int d = 0; d < 4; d++) begin
      if (count[d] != '0 && coin_value(2'(d)) <= remaining) begin
        pick_found = 1'b1;
        pick_type  = 2'(d);
      end
    end
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (i_reset) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (bus.i_req_valid)
               state_next = (bus.i_req_amount == '0) ? DONE : PICK;
      PICK:  state_next = pick_found ? ISSUE : DONE;
      ISSUE: if (bus.i_coin_ack)
               state_next = (remaining_after == '0) ? DONE : PICK;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Amount tracking, selected coin and shortfall result.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      remaining <= '0;
      coin_type <= 2'd0;
      short_q   <= 1'b0;
      short_amt <= '0;
    end else begin
      case (state)
        IDLE: if (bus.i_req_valid) begin
          remaining <= bus.i_req_amount;
          short_q   <= 1'b0;
          short_amt <= '0;
        end
        PICK: if (pick_found) begin
          coin_type <= pick_type;
        end else begin
          short_q   <= 1'b1;
          short_amt <= remaining;
        end
        ISSUE: if (bus.i_coin_ack) remaining <= remaining_after;
        default: ;
      endcase
    end
  end

  // Inventory counters: ack decrements, refill increments with saturation;
  // both on the same denomination cancel out.
  always_ff @(posedge i_clk or posedge i_reset) begin
    // NOTE: the four counters are a tiny register file, not a RAM, so they
    // are reset to a known inventory like any other state.
    if (i_reset) begin
      for (int d = 0; d < 4; d++) count[d] <= CNT_INIT;
    end else begin
      for (int d = 0; d < 4; d++) begin
        if (bus.i_refill && bus.i_refill_type == 2'(d) &&
            !(ack_take && coin_type == 2'(d))) begin
          if (count[d] != CNT_MAX) count[d] <= count[d] + CNT_W'(1);
        end else if (ack_take && coin_type == 2'(d) &&
                     !(bus.i_refill && bus.i_refill_type == 2'(d))) begin
          count[d] <= count[d] - CNT_W'(1);
        end
      end
    end
  end

  // Empty flags follow the counters directly.
  always_comb begin
    for (int d = 0; d < 4; d++) bus.o_empty[d] = (count[d] == '0);
  end

  assign bus.o_req_ready    = (state == IDLE);
  assign bus.o_coin_valid   = (state == ISSUE);
  assign bus.o_coin_type    = coin_type;
  assign bus.o_done         = (state == DONE);
  assign bus.o_short        = short_q;
  assign bus.o_short_amount = short_amt;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: two instances (full inventory and a single
// coin per denomination) share one stimulus bus selected by sel_b; expected
// coins are queued per request and popped as the DUT presents them.
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sel_b = 1'b0;
  logic       req_valid = 1'b0;
  logic [7:0] req_amount = '0;
  logic       coin_ack = 1'b0;
  logic       refill = 1'b0;
  logic [1:0] refill_type = '0;

  logic       req_ready, coin_valid, done, short_o;
  logic [1:0] coin_type;
  logic [7:0] short_amount;
  logic [3:0] empty;

  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0] exp_coins [$];
  int exp_cnt [4];

  always #5 clk = ~clk;

  change_dispenser_if #(.AMT_W(8)) ifa ();
  change_dispenser_if #(.AMT_W(8)) ifb ();

  assign ifa.i_req_valid   = req_valid & ~sel_b;
  assign ifa.i_req_amount  = req_amount;
  assign ifa.i_coin_ack    = coin_ack & ~sel_b;
  assign ifa.i_refill      = refill & ~sel_b;
  assign ifa.i_refill_type = refill_type;
  assign ifb.i_req_valid   = req_valid & sel_b;
  assign ifb.i_req_amount  = req_amount;
  assign ifb.i_coin_ack    = coin_ack & sel_b;
  assign ifb.i_refill      = refill & sel_b;
  assign ifb.i_refill_type = refill_type;

  assign req_ready    = sel_b ? ifb.o_req_ready    : ifa.o_req_ready;
  assign coin_valid   = sel_b ? ifb.o_coin_valid   : ifa.o_coin_valid;
  assign coin_type    = sel_b ? ifb.o_coin_type    : ifa.o_coin_type;
  assign done         = sel_b ? ifb.o_done         : ifa.o_done;
  assign short_o      = sel_b ? ifb.o_short        : ifa.o_short;
  assign short_amount = sel_b ? ifb.o_short_amount : ifa.o_short_amount;
  assign empty        = sel_b ? ifb.o_empty        : ifa.o_empty;

  change_dispenser #(.AMT_W(8), .CNT_W(6), .INIT_CNT(10)) dut_a (
    .i_clk(clk), .i_reset(rst), .bus(ifa.slave)
  );
  change_dispenser #(.AMT_W(8), .CNT_W(6), .INIT_CNT(1)) dut_b (
    .i_clk(clk), .i_reset(rst), .bus(ifb.slave)
  );

  function automatic int cnt_a(input int d);
    case (d)
      0: cnt_a = int'(dut_a.count[0]);
      1: cnt_a = int'(dut_a.count[1]);
      2: cnt_a = int'(dut_a.count[2]);
      default: cnt_a = int'(dut_a.count[3]);
    endcase
  endfunction

  task automatic compare_counts(input string name);
    for (int d = 0; d < 4; d++) begin
      n_checks++;
      if (cnt_a(d) !== exp_cnt[d]) begin
        n_fail++;
        $display("FAIL %s count[%0d]: got %0d expected %0d", name, d, cnt_a(d), exp_cnt[d]);
      end
    end
  endtask

  // Issue one request, answer coins from the scoreboard, check the result.
  task automatic do_request(input logic [7:0] amount, input int ack_gap,
                            input bit stall_req, input bit refill_on_ack,
                            input bit exp_short, input logic [7:0] exp_amt,
                            input int exp_first);
    int cyc = 0;
    bit seen_first = 0;
    bit finished = 0;
    bit just_acked = 0;
    logic [1:0] got;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL req_ready_before: got %b expected 1", req_ready);
    end
    req_valid = 1'b1; req_amount = amount;
    @(posedge clk); #1 req_valid = 1'b0;
    while (!finished && cyc < 200) begin
      @(negedge clk); cyc++;
      if (just_acked) begin
        just_acked = 0;
        n_checks++;
        if (coin_valid !== 1'b0) begin
          n_fail++; $display("FAIL coin_valid_drop: got %b expected 0", coin_valid);
        end
      end
      if (done === 1'b1) begin
        finished = 1;
        if (!seen_first) begin
          n_checks++;
          if (cyc != exp_first) begin
            n_fail++; $display("FAIL done_latency: got %0d expected %0d", cyc, exp_first);
          end
        end
        n_checks++;
        if (short_o !== exp_short || short_amount !== exp_amt) begin
          n_fail++;
          $display("FAIL short_result: got %b/%0d expected %b/%0d", short_o, short_amount, exp_short, exp_amt);
        end
        n_checks++;
        if (exp_coins.size() != 0) begin
          n_fail++; $display("FAIL coins_missing: got %0d left expected 0", exp_coins.size());
          exp_coins.delete();
        end
      end else if (coin_valid === 1'b1) begin
        if (!seen_first) begin
          seen_first = 1;
          n_checks++;
          if (cyc != exp_first) begin
            n_fail++; $display("FAIL first_coin_latency: got %0d expected %0d", cyc, exp_first);
          end
        end
        got = coin_type;
        n_checks++;
        if (exp_coins.size() == 0) begin
          n_fail++; $display("FAIL unexpected_coin: got type %0d expected none", got);
        end else begin
          logic [1:0] e;
          e = exp_coins.pop_front();
          if (got !== e) begin
            n_fail++; $display("FAIL coin_type: got %0d expected %0d", got, e);
          end
        end
        for (int g = 0; g < ack_gap; g++) begin
          if (stall_req) begin req_valid = 1'b1; req_amount = 8'd99; end
          @(negedge clk); cyc++;
          n_checks++;
          if (coin_valid !== 1'b1 || coin_type !== got) begin
            n_fail++;
            $display("FAIL stall_stable: got %b/%0d expected 1/%0d", coin_valid, coin_type, got);
          end
          if (!sel_b) begin
            n_checks++;
            if (cnt_a(int'(got)) !== exp_cnt[got]) begin
              n_fail++;
              $display("FAIL stall_count: got %0d expected %0d", cnt_a(int'(got)), exp_cnt[got]);
            end
          end
        end
        req_valid = 1'b0;
        coin_ack = 1'b1;
        if (refill_on_ack) begin refill = 1'b1; refill_type = got; end
        @(posedge clk); #1;
        coin_ack = 1'b0; refill = 1'b0;
        if (!sel_b && !refill_on_ack) exp_cnt[got] = exp_cnt[got] - 1;
        just_acked = 1;
      end
    end
    if (!finished) begin
      n_checks++; n_fail++;
      $display("FAIL request_timeout: got no done expected done within 200 cycles");
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || req_ready !== 1'b1 || short_o !== exp_short || short_amount !== exp_amt) begin
      n_fail++;
      $display("FAIL after_done: got done=%b ready=%b short=%b/%0d expected 0/1/%b/%0d",
               done, req_ready, short_o, short_amount, exp_short, exp_amt);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1 || coin_valid !== 1'b0 || coin_type !== 2'd0 || done !== 1'b0 ||
        short_o !== 1'b0 || short_amount !== 8'd0 || empty !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b cv=%b ct=%0d dn=%b sh=%b sa=%0d em=%b expected 1 0 0 0 0 0 0000",
               req_ready, coin_valid, coin_type, done, short_o, short_amount, empty);
    end
    compare_counts("reset");
  endtask

  task automatic test_normal_payout();
    exp_coins.push_back(2'd3); exp_coins.push_back(2'd2); exp_coins.push_back(2'd1);
    do_request(8'd40, 0, 0, 0, 1'b0, 8'd0, 2);
    compare_counts("normal_payout");
  endtask

  task automatic test_zero_amount();
    do_request(8'd0, 0, 0, 0, 1'b0, 8'd0, 1);
  endtask

  task automatic test_stalled_ack();
    exp_coins.push_back(2'd3);
    do_request(8'd25, 5, 1, 0, 1'b0, 8'd0, 2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (coin_valid !== 1'b0 || req_ready !== 1'b1) begin
        n_fail++; $display("FAIL ignored_req: got cv=%b rdy=%b expected 0/1", coin_valid, req_ready);
      end
    end
    coin_ack = 1'b1;
    @(posedge clk); #1 coin_ack = 1'b0;
    @(negedge clk);
    n_checks++;
    if (coin_valid !== 1'b0 || req_ready !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL idle_ack: got cv=%b rdy=%b dn=%b expected 0/1/0", coin_valid, req_ready, done);
    end
    compare_counts("stalled_ack");
  endtask

  task automatic test_refill_corners();
    exp_coins.push_back(2'd3);
    do_request(8'd25, 0, 0, 1, 1'b0, 8'd0, 2);
    compare_counts("refill_same_cycle");
    refill = 1'b1; refill_type = 2'd0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      exp_cnt[0] = (exp_cnt[0] < 63) ? exp_cnt[0] + 1 : 63;
    end
    refill = 1'b0;
    @(negedge clk);
    compare_counts("refill_saturate");
  endtask

  task automatic test_exhaustion();
    sel_b = 1'b1;
    exp_coins.push_back(2'd3); exp_coins.push_back(2'd2);
    exp_coins.push_back(2'd1); exp_coins.push_back(2'd0);
    do_request(8'd41, 0, 0, 0, 1'b0, 8'd0, 2);
    n_checks++;
    if (empty !== 4'b1111) begin
      n_fail++; $display("FAIL empty_flags: got %b expected 1111", empty);
    end
    do_request(8'd7, 0, 0, 0, 1'b1, 8'd7, 2);
    do_request(8'd0, 0, 0, 0, 1'b0, 8'd0, 1);
    sel_b = 1'b0;
  endtask

  task automatic test_reset_issue();
    int waited = 0;
    @(negedge clk);
    req_valid = 1'b1; req_amount = 8'd25;
    @(posedge clk); #1 req_valid = 1'b0;
    while (coin_valid !== 1'b1 && waited < 20) begin @(negedge clk); waited++; end
    n_checks++;
    if (coin_valid !== 1'b1) begin
      n_fail++; $display("FAIL reset_issue_setup: got cv=%b expected 1", coin_valid);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (coin_valid !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: got cv=%b dn=%b expected 0/0", coin_valid, done);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0) begin
        n_fail++; $display("FAIL reset_done_pulse: got %b expected 0", done);
      end
    end
    for (int d = 0; d < 4; d++) exp_cnt[d] = 10;
    compare_counts("reset_issue");
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1 || coin_valid !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL post_reset: got rdy=%b cv=%b dn=%b expected 1/0/0", req_ready, coin_valid, done);
    end
  endtask

  initial begin
    for (int d = 0; d < 4; d++) exp_cnt[d] = 10;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_normal_payout();
    test_zero_amount();
    test_stalled_ack();
    test_refill_corners();
    test_exhaustion();
    test_reset_issue();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
